// File: rtl/alu_stream.sv
`default_nettype none
// ============================================================================
// Module      : alu_stream
// Description : Streaming ALU with valid/ready handshakes on input and output.
//               Single-cycle ADD/SUB/AND/OR/XOR/SLT/SLL. When the macro
//               ALU_STREAM_MUL_EN is defined, opcode 111 runs an iterative
//               shift-add multiply (WIDTH cycles). When it is undefined,
//               opcode 111 behaves as ADD.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_stream #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] c_op_add = 3'b000;
  localparam logic [2:0] c_op_sub = 3'b001;
  localparam logic [2:0] c_op_and = 3'b010;
  localparam logic [2:0] c_op_or  = 3'b011;
  localparam logic [2:0] c_op_xor = 3'b100;
  localparam logic [2:0] c_op_slt = 3'b101;
  localparam logic [2:0] c_op_sll = 3'b110;
  localparam logic [2:0] c_op_mul = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef ALU_STREAM_MUL_EN
    S_MUL  = 2'd2,
`endif
    S_HOLD = 2'd1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_result;
  logic             r_out_valid;
  logic             r_zero;
  logic             r_carry;
  logic             r_ovf;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_slt;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;
  logic             w_accept;

  // Extra top bit captures ADD carry-out and SUB unsigned borrow.
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};
  assign w_slt  = ($signed(a) < $signed(b));

  // Single-cycle datapath; opcode 111 falls through to ADD when no multiplier.
  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (op)
      c_op_sub: begin
        w_res   = w_diff[WIDTH-1:0];
        w_carry = w_diff[WIDTH];
        w_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      c_op_and: w_res = a & b;
      c_op_or:  w_res = a | b;
      c_op_xor: w_res = a ^ b;
      c_op_slt: w_res = {{(WIDTH-1){1'b0}}, w_slt};
      c_op_sll: w_res = a << b[SHW-1:0];
      default: begin
        // c_op_add and c_op_mul (the latter only reaches here without MUL)
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
    endcase
  end

  // Held low during reset so nothing is accepted until rst_n deasserts.
  assign in_ready = rst_n && ((r_state == S_IDLE) || ((r_state == S_HOLD) && out_ready));
  assign w_accept = in_valid && in_ready;

`ifdef ALU_STREAM_MUL_EN
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [SHW-1:0]   r_cnt;
  logic             r_busy;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             w_mul_last;

  assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_last = (r_cnt == SHW'(WIDTH - 1));
  assign busy       = r_busy;
`else
  assign busy       = 1'b0;
`endif

  // Control FSM plus registered result/flags and multiplier datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_result    <= '0;
      r_out_valid <= 1'b0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
`ifdef ALU_STREAM_MUL_EN
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_HOLD: begin
          if (w_accept) begin
`ifdef ALU_STREAM_MUL_EN
            if (op == c_op_mul) begin
              r_state     <= S_MUL;
              r_busy      <= 1'b1;
              r_out_valid <= 1'b0;
              r_acc       <= '0;
              r_mcand     <= a;
              r_mplier    <= b;
              r_cnt       <= '0;
            end else
`endif
            begin
              // Back-to-back from HOLD replaces the result with no bubble.
              r_result    <= w_res;
              r_zero      <= (w_res == '0);
              r_carry     <= w_carry;
              r_ovf       <= w_ovf;
              r_out_valid <= 1'b1;
              r_state     <= S_HOLD;
            end
          end else if ((r_state == S_HOLD) && out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
`ifdef ALU_STREAM_MUL_EN
        S_MUL: begin
          // One multiplier bit per cycle; the last step publishes the sum.
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (w_mul_last) begin
            r_result    <= w_acc_nxt;
            r_zero      <= (w_acc_nxt == '0);
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_HOLD;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign carry     = r_carry;
  assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_alu_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_stream
// Description : Directed self-checking bench for alu_stream (WIDTH=32).
//               MUL checks follow the ALU_STREAM_MUL_EN macro setting.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_stream;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             overflow;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  alu_stream #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .overflow  (overflow),
    .busy      (busy)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one bundle for a cycle, then scramble operands to show they
  // were captured at the transfer.
  task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
    op       = o;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    op       = 3'($urandom_range(0, 6));
  endtask

  task automatic chk_out(input string tag, input logic [31:0] r, input logic z,
                         input logic c, input logic v);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_result"}, 64'(result), 64'(r));
    chk({tag, "_zero"}, 64'(zero), 64'(z));
    chk({tag, "_carry"}, 64'(carry), 64'(c));
    chk({tag, "_ovf"}, 64'(overflow), 64'(v));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    op        = 3'b000;

    // Reset state
    repeat (3) tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_zero", 64'(zero), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    // ADD wrap: FFFFFFFF + 1 = 0, carry out
    issue(3'b000, 32'hFFFF_FFFF, 32'h1);
    chk_out("add_wrap", 32'h0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("add_drain_valid", 64'(out_valid), 64'd0);

    // SUB signed overflow
    issue(3'b001, 32'h8000_0000, 32'h1);
    chk_out("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
    tick();

    // SUB borrow
    issue(3'b001, 32'h1, 32'h2);
    chk_out("sub_borrow", 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
    tick();

    // ADD signed overflow
    issue(3'b000, 32'h7FFF_FFFF, 32'h1);
    chk_out("add_ovf", 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    tick();

    // SLT: -1 < 1
    issue(3'b101, 32'hFFFF_FFFF, 32'h1);
    chk_out("slt", 32'h1, 1'b0, 1'b0, 1'b0);
    tick();

    // SLL ignores upper bits of b: 0x25 -> shift 5
    issue(3'b110, 32'h1, 32'h25);
    chk_out("sll", 32'h20, 1'b0, 1'b0, 1'b0);
    tick();

    // Logic ops
    issue(3'b010, 32'hF0F0_1234, 32'hFF00_FFFF);
    chk_out("and", 32'hF000_1234, 1'b0, 1'b0, 1'b0);
    tick();
    issue(3'b011, 32'h0F00_0001, 32'h00F0_0010);
    chk_out("or", 32'h0FF0_0011, 1'b0, 1'b0, 1'b0);
    tick();
    issue(3'b100, 32'hA5A5_5A5A, 32'hA5A5_5A5A);
    chk_out("xor", 32'h0, 1'b1, 1'b0, 1'b0);
    tick();

`ifdef ALU_STREAM_MUL_EN
    // MUL 7*6: busy for 32 cycles, valid in cycle 33
    begin
      int busy_cnt  = 0;
      int valid_cyc = 0;
      issue(3'b111, 32'd7, 32'd6);
      chk("mul_in_ready", 64'(in_ready), 64'd0);
      for (int i = 1; i <= 40; i++) begin
        if (out_valid) begin
          valid_cyc = i;
          break;
        end
        if (busy) busy_cnt++;
        tick();
      end
      chk("mul_busy_cycles", 64'(busy_cnt), 64'd32);
      chk("mul_valid_cycle", 64'(valid_cyc), 64'd33);
      chk("mul_busy_done", 64'(busy), 64'd0);
      chk_out("mul", 32'd42, 1'b0, 1'b0, 1'b0);
      tick();
    end
`else
    // Without the multiplier opcode 111 is ADD with latency 1
    issue(3'b111, 32'd7, 32'd6);
    chk_out("mul_as_add", 32'd13, 1'b0, 1'b0, 1'b0);
    chk("mul_as_add_busy", 64'(busy), 64'd0);
    tick();
`endif

    // Backpressure: 3+4 held for 5 cycles, then back-to-back 1+1
    out_ready = 1'b0;
    issue(3'b000, 32'd3, 32'd4);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_result", 64'(result), 64'd7);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    op        = 3'b000;
    a         = 32'd1;
    b         = 32'd1;
    in_valid  = 1'b1;
    #1;
    chk("release_in_ready", 64'(in_ready), 64'd1);
    chk("release_result", 64'(result), 64'd7);
    tick();
    in_valid = 1'b0;
    chk_out("b2b", 32'd2, 1'b0, 1'b0, 1'b0);
    tick();
    chk("b2b_drain_valid", 64'(out_valid), 64'd0);

`ifdef ALU_STREAM_MUL_EN
    // Reset in cycle 10 of MUL aborts it
    issue(3'b111, 32'd7, 32'd6);
    repeat (9) tick();
    chk("mul_mid_busy", 64'(busy), 64'd1);
`else
    // Reset while a result is held aborts it
    out_ready = 1'b0;
    issue(3'b000, 32'd5, 32'd5);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
`endif
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_result", 64'(result), 64'd0);
    chk("arst_zero", 64'(zero), 64'd0);
    chk("arst_carry", 64'(carry), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    issue(3'b000, 32'd2, 32'd2);
    chk_out("post_rst_add", 32'd4, 1'b0, 1'b0, 1'b0);
    tick();
    chk("post_rst_drain", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
